// File: rtl/pixel_framebuffer_if.sv
// Pixel write and page-swap port between the host/draw logic and the framebuffer.
interface pixel_framebuffer_if #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 683,
  parameter int unsigned BPP    = 3
);
  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic          WR_VALID;
  logic          WR_READY;
  logic [XW-1:0] WR_X;
  logic [YW-1:0] WR_Y;
  logic [BPP-1:0] WR_DATA;
  logic          WR_ERR;
  logic          SWAP_REQ;
  logic          SWAP_DONE;

  modport master (
    output WR_VALID, WR_X, WR_Y, WR_DATA, SWAP_REQ,
    input  WR_READY, WR_ERR, SWAP_DONE
  );

  modport slave (
    input  WR_VALID, WR_X, WR_Y, WR_DATA, SWAP_REQ,
    output WR_READY, WR_ERR, SWAP_DONE
  );
endinterface

// File: rtl/pixel_framebuffer.sv
// Optionally double-buffered pixel framebuffer: host writes the back page,
// VGA timing reads the front page through a 2-cycle pipeline, pages swap at frame start.
module pixel_framebuffer #(
  parameter int unsigned H_L        = 896,
  parameter int unsigned V_L        = 795,
  parameter int unsigned WIDTH      = 768,
  parameter int unsigned HEIGHT     = 683,
  parameter int unsigned BPP        = 3,
  parameter int unsigned SCALE_SH   = 0,
  parameter int unsigned DOUBLE_BUF = 1,
  localparam int unsigned HW        = $clog2(H_L),
  localparam int unsigned VW        = $clog2(V_L)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [HW-1:0]  H_count,
  input  logic [VW-1:0]  V_count,
  input  logic           SEL,
  output logic [BPP-1:0] OUT,
  output logic           FRONT,
  pixel_framebuffer_if.slave wr
);
  localparam int unsigned PAGES   = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int unsigned PAGE_SZ = HEIGHT * WIDTH;
  localparam int unsigned DEPTH   = PAGES * PAGE_SZ;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic [BPP-1:0] mem [DEPTH];

  logic [HW-1:0] col_c;
  logic [VW-1:0] row_c;
  logic [HW-1:0] col_q;
  logic [VW-1:0] row_q;
  logic          inr_q;
  logic          pending;
  logic          frame_start;
  logic          wr_accept;
  logic          wr_in_range;
  logic          wpage;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Address decode for both ports; write lands on the page not being displayed.
  always_comb begin
    col_c       = H_count >> SCALE_SH;
    row_c       = V_count >> SCALE_SH;
    frame_start = (H_count == '0) && (V_count == '0);
    wr_accept   = wr.WR_VALID && wr.WR_READY && !RST;
    wr_in_range = (32'(wr.WR_X) < WIDTH) && (32'(wr.WR_Y) < HEIGHT);
    wpage       = (DOUBLE_BUF != 0) ? ~FRONT : 1'b0;
    wr_addr     = AW'(32'(wpage) * PAGE_SZ + 32'(wr.WR_Y) * WIDTH + 32'(wr.WR_X));
    rd_addr     = AW'(32'(FRONT) * PAGE_SZ + 32'(row_q) * WIDTH + 32'(col_q));
  end

  // Pixel store; never reset, out-of-range writes are dropped.
  always_ff @(posedge CLK) begin
    if (wr_accept && wr_in_range) begin
      mem[wr_addr] <= wr.WR_DATA;
    end
  end

  // Two-stage read: register position/in-range, then fetch or blank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q <= '0;
      row_q <= '0;
      inr_q <= 1'b0;
      OUT   <= '0;
    end else begin
      col_q <= col_c;
      row_q <= row_c;
      inr_q <= SEL && (32'(col_c) < WIDTH) && (32'(row_c) < HEIGHT);
      OUT   <= inr_q ? mem[rd_addr] : '0;
    end
  end

  // Write handshake status and frame-aligned page swap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr.WR_READY  <= 1'b0;
      wr.WR_ERR    <= 1'b0;
      wr.SWAP_DONE <= 1'b0;
      FRONT        <= 1'b0;
      pending      <= 1'b0;
    end else begin
      wr.WR_READY  <= 1'b1;
      wr.WR_ERR    <= wr_accept && !wr_in_range;
      wr.SWAP_DONE <= 1'b0;
      if (frame_start && (pending || wr.SWAP_REQ)) begin
        if (DOUBLE_BUF != 0) begin
          FRONT <= ~FRONT;
        end
        pending      <= 1'b0;
        wr.SWAP_DONE <= 1'b1;
      end else if (wr.SWAP_REQ) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench: full-size double-buffered instance plus a small scaled single-page instance.
module tb_pixel_framebuffer;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic [9:0] ha;
  logic [9:0] va;
  logic       sela;
  logic [2:0] outa;
  logic       fronta;
  pixel_framebuffer_if #(.WIDTH(768), .HEIGHT(683), .BPP(3)) wa ();

  logic [4:0] hb;
  logic [3:0] vb;
  logic       selb;
  logic [2:0] outb;
  logic       frontb;
  pixel_framebuffer_if #(.WIDTH(8), .HEIGHT(4), .BPP(3)) wb ();

  pixel_framebuffer #(
    .H_L(896), .V_L(795), .WIDTH(768), .HEIGHT(683),
    .BPP(3), .SCALE_SH(0), .DOUBLE_BUF(1)
  ) u_a (
    .CLK(CLK), .RST(RST), .H_count(ha), .V_count(va), .SEL(sela),
    .OUT(outa), .FRONT(fronta), .wr(wa.slave)
  );

  pixel_framebuffer #(
    .H_L(32), .V_L(16), .WIDTH(8), .HEIGHT(4),
    .BPP(3), .SCALE_SH(1), .DOUBLE_BUF(0)
  ) u_b (
    .CLK(CLK), .RST(RST), .H_count(hb), .V_count(vb), .SEL(selb),
    .OUT(outb), .FRONT(frontb), .wr(wb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_a(input int x, input int y, input int d);
    wa.WR_VALID = 1'b1;
    wa.WR_X     = 10'(x);
    wa.WR_Y     = 10'(y);
    wa.WR_DATA  = 3'(d);
    step();
    wa.WR_VALID = 1'b0;
  endtask

  task automatic wr_b(input int x, input int y, input int d);
    wb.WR_VALID = 1'b1;
    wb.WR_X     = 3'(x);
    wb.WR_Y     = 2'(y);
    wb.WR_DATA  = 3'(d);
    step();
    wb.WR_VALID = 1'b0;
  endtask

  task automatic rd_a(input string tag, input int h, input int v, input logic s, input int exp);
    ha   = 10'(h);
    va   = 10'(v);
    sela = s;
    step();
    step();
    check(tag, 32'(outa), 32'(exp));
  endtask

  task automatic rd_b(input string tag, input int h, input int v, input int exp);
    hb   = 5'(h);
    vb   = 4'(v);
    selb = 1'b1;
    step();
    step();
    check(tag, 32'(outb), 32'(exp));
  endtask

  initial begin
    RST  = 1'b1;
    ha   = 10'd5;
    va   = 10'd2;
    sela = 1'b1;
    wa.WR_VALID = 1'b0; wa.WR_X = '0; wa.WR_Y = '0; wa.WR_DATA = '0; wa.SWAP_REQ = 1'b0;
    hb   = 5'd3;
    vb   = 4'd3;
    selb = 1'b1;
    wb.WR_VALID = 1'b0; wb.WR_X = '0; wb.WR_Y = '0; wb.WR_DATA = '0; wb.SWAP_REQ = 1'b0;

    // Reset held during active video.
    repeat (3) step();
    check("rst_out_a",   32'(outa), 32'd0);
    check("rst_ready_a", 32'(wa.WR_READY), 32'd0);
    check("rst_front_a", 32'(fronta), 32'd0);
    check("rst_err_a",   32'(wa.WR_ERR), 32'd0);
    check("rst_done_a",  32'(wa.SWAP_DONE), 32'd0);
    check("rst_ready_b", 32'(wb.WR_READY), 32'd0);
    RST = 1'b0;
    step();
    check("ready_after_rst_a", 32'(wa.WR_READY), 32'd1);
    check("ready_after_rst_b", 32'(wb.WR_READY), 32'd1);

    // Back-page writes (FRONT=0 so these go to page 1) and range errors.
    ha = 10'd100; va = 10'd50;
    wr_a(5, 2, 5);
    wr_a(2, 5, 2);
    wr_a(0, 3, 6);
    wr_a(768, 2, 1);
    check("err_x", 32'(wa.WR_ERR), 32'd1);
    step();
    check("err_x_clear", 32'(wa.WR_ERR), 32'd0);
    wr_a(0, 683, 1);
    check("err_y", 32'(wa.WR_ERR), 32'd1);
    step();

    // Swap requested mid-frame waits for frame start; repeat request collapses.
    wa.SWAP_REQ = 1'b1;
    step();
    wa.SWAP_REQ = 1'b0;
    check("swap_wait_front", 32'(fronta), 32'd0);
    check("swap_wait_done",  32'(wa.SWAP_DONE), 32'd0);
    step();
    wa.SWAP_REQ = 1'b1;
    step();
    wa.SWAP_REQ = 1'b0;
    step();
    check("swap_wait_front2", 32'(fronta), 32'd0);
    ha = 10'd0; va = 10'd0;
    step();
    check("swap_front", 32'(fronta), 32'd1);
    check("swap_done",  32'(wa.SWAP_DONE), 32'd1);
    ha = 10'd100; va = 10'd50;
    step();
    check("swap_done_once", 32'(wa.SWAP_DONE), 32'd0);
    check("swap_single",    32'(fronta), 32'd1);

    // Orientation and the dropped out-of-range write.
    rd_a("pix_x5_y2", 5, 2, 1'b1, 5);
    rd_a("pix_x2_y5", 2, 5, 1'b1, 2);
    rd_a("pix_x0_y3_untouched", 0, 3, 1'b1, 6);

    // Write to page 0 stays hidden while page 1 is displayed.
    wr_a(5, 2, 3);
    rd_a("back_hidden", 5, 2, 1'b1, 5);

    // Swap request at frame start, with a write in the same cycle (pre-swap page 0).
    ha = 10'd0; va = 10'd0;
    wa.SWAP_REQ = 1'b1;
    wa.WR_VALID = 1'b1; wa.WR_X = 10'd6; wa.WR_Y = 10'd2; wa.WR_DATA = 3'd7;
    step();
    wa.SWAP_REQ = 1'b0;
    wa.WR_VALID = 1'b0;
    check("swap_now_front", 32'(fronta), 32'd0);
    check("swap_now_done",  32'(wa.SWAP_DONE), 32'd1);
    ha = 10'd100; va = 10'd50;
    step();
    check("swap_now_done_clr", 32'(wa.SWAP_DONE), 32'd0);
    rd_a("after_swap_x5_y2", 5, 2, 1'b1, 3);
    rd_a("swap_cycle_write", 6, 2, 1'b1, 7);

    // Blanking.
    rd_a("blank_sel", 5, 2, 1'b0, 0);
    rd_a("blank_h",   768, 2, 1'b1, 0);

    // Exact 2-cycle latency.
    ha = 10'd5; va = 10'd2; sela = 1'b0;
    step();
    step();
    sela = 1'b1;
    step();
    check("latency_1cyc", 32'(outa), 32'd0);
    step();
    check("latency_2cyc", 32'(outa), 32'd3);

    // Reset discards a pending swap.
    ha = 10'd100; va = 10'd50;
    wa.SWAP_REQ = 1'b1;
    step();
    wa.SWAP_REQ = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    ha = 10'd0; va = 10'd0;
    step();
    check("rst_drop_swap_done",  32'(wa.SWAP_DONE), 32'd0);
    check("rst_drop_swap_front", 32'(fronta), 32'd0);
    ha = 10'd100; va = 10'd50;
    step();

    // Scaled single-page instance: each stored pixel covers 2x2 counts.
    wr_b(1, 1, 3);
    wr_b(2, 1, 4);
    for (int h = 2; h <= 3; h++) begin
      for (int v = 2; v <= 3; v++) begin
        rd_b($sformatf("scale_h%0d_v%0d", h, v), h, v, 3);
      end
    end
    rd_b("scale_neighbour", 4, 2, 4);

    // Same-cycle read and write of one location returns old data first.
    hb = 5'd2; vb = 4'd2;
    step();
    wb.WR_VALID = 1'b1; wb.WR_X = 3'd1; wb.WR_Y = 2'd1; wb.WR_DATA = 3'd6;
    step();
    wb.WR_VALID = 1'b0;
    check("raw_old", 32'(outb), 32'd3);
    step();
    check("raw_new", 32'(outb), 32'd6);

    // Single-page swap still pulses SWAP_DONE, FRONT stays 0.
    wb.SWAP_REQ = 1'b1;
    step();
    wb.SWAP_REQ = 1'b0;
    hb = 5'd0; vb = 4'd0;
    step();
    check("single_swap_done",  32'(wb.SWAP_DONE), 32'd1);
    check("single_swap_front", 32'(frontb), 32'd0);
    hb = 5'd3;
    step();
    check("single_swap_done_clr", 32'(wb.SWAP_DONE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
